// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch sequencer that reads instruction memory at the PC
// and strobes pc_update with PC+4; faults on a misaligned PC or a memory timeout.
module instr_fetch_unit #(
    parameter int BUS_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_start,
    input  logic [BUS_WIDTH-1:0] curr_addr,
    output logic                 mem_req,
    output logic [BUS_WIDTH-1:0] mem_addr,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 pc_update,
    output logic [BUS_WIDTH-1:0] next_addr,
    output logic [BUS_WIDTH-1:0] instr,
    output logic                 instr_valid,
    output logic                 busy,
    output logic                 fault
);
    typedef enum logic [1:0] {IDLE, REQ, UPD, ERR} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    localparam logic [BUS_WIDTH-1:0] NOP = BUS_WIDTH'(32'h00000013);

    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d, next_q, next_d, instr_q, instr_d;
    logic req_q, req_d, upd_q, upd_d, valid_q, valid_d, busy_q, busy_d, fault_q, fault_d;
    logic accept, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            next_q  <= '0;
            instr_q <= NOP;
            req_q   <= 1'b0;
            upd_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            upd_q   <= upd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_start) state_d = (curr_addr[1:0] == 2'b00) ? REQ : ERR;
            REQ:     state_d = mem_ready ? UPD : (cnt_q == LAST) ? ERR : REQ;
            UPD:     state_d = IDLE;
            default: state_d = ERR;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        accept  = (state_q == IDLE) && (state_d == REQ);
        done    = (state_q == REQ) && mem_ready;
        cnt_d   = (state_q == REQ) ? cnt_q + 8'd1 : 8'd0;
        addr_d  = accept ? curr_addr : addr_q;
        next_d  = done ? addr_q + BUS_WIDTH'(4) : next_q;
        instr_d = done ? mem_rdata : instr_q;
        valid_d = accept ? 1'b0 : (state_d == UPD) ? 1'b1 : valid_q;
        req_d   = (state_d == REQ);
        upd_d   = (state_d == UPD);
        busy_d  = (state_d == REQ) || (state_d == UPD);
        fault_d = (state_d == ERR);
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign pc_update   = upd_q;
    assign next_addr   = next_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven fetches with a pc_update scoreboard, plus
// hand-written misaligned, timeout and mid-fetch reset sequences.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_start = 1'b0;
    logic [31:0] curr_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        pc_update;
    logic [31:0] next_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        busy;
    logic        fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          wt;
        logic [31:0] exp_next;
    } vec_t;
    typedef struct {
        logic [31:0] nxt;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];
    vec_t vecs[4];

    instr_fetch_unit #(.BUS_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .curr_addr(curr_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_update(pc_update), .next_addr(next_addr), .instr(instr),
        .instr_valid(instr_valid), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every pc_update must match the oldest outstanding fetch.
    logic prev_pu = 1'b0;
    always @(negedge clk) begin
        if (pc_update) begin
            if (sb.size() == 0) begin
                chk("unexpected_pc_update", 32'(pc_update), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_next_addr", next_addr, e.nxt);
                chk("sb_instr", instr, e.ins);
                chk("sb_instr_valid", 32'(instr_valid), 32'd1);
            end
        end
        if (prev_pu && pc_update) chk("pc_update_double", 32'd1, 32'd0);
        prev_pu = pc_update;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_pc_update"}, 32'(pc_update), 32'd0);
        chk({tag, "_next_addr"}, next_addr, 32'd0);
        chk({tag, "_instr"}, instr, 32'h00000013);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    task automatic do_fetch(input vec_t v);
        int req_cycles;
        int pc_cycle;
        exp_t e;
        e.nxt = v.exp_next;
        e.ins = v.rdata;
        sb.push_back(e);
        curr_addr   = v.addr;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("accept_clears_valid", 32'(instr_valid), 32'd0);
        req_cycles = 0;
        pc_cycle   = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_req) begin
                req_cycles++;
                if (mem_addr !== v.addr) chk("mem_addr_held", mem_addr, v.addr);
            end
            if (pc_update) begin
                pc_cycle = c;
                break;
            end
            mem_ready   = (c == v.wt + 1);
            mem_rdata   = mem_ready ? v.rdata : 32'hDEADBEEF;
            fetch_start = busy && (c % 2 == 0);
            curr_addr   = 32'h00000800;
            step();
            mem_ready   = 1'b0;
            fetch_start = 1'b0;
        end
        chk("req_cycles", 32'(req_cycles), 32'(v.wt + 1));
        chk("pc_update_cycle", 32'(pc_cycle), 32'(v.wt + 2));
        chk("mem_addr", mem_addr, v.addr);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        chk("idle_next_addr_kept", next_addr, v.exp_next);
    endtask

    initial begin
        int fault_cycle;
        int reqs;
        vecs[0] = '{32'h00000100, 32'h00500093, 0, 32'h00000104};
        vecs[1] = '{32'h00000100, 32'h00A00113, 3, 32'h00000104};
        vecs[2] = '{32'hFFFFFFFC, 32'h12345678, 1, 32'h00000000};
        vecs[3] = '{32'h00000040, 32'hCAFEF00D, 2, 32'h00000044};

        step();
        do_reset();
        check_reset_vals("reset");

        foreach (vecs[i]) do_fetch(vecs[i]);

        // mem_ready outside REQ must not disturb the latched instruction.
        mem_ready = 1'b1;
        mem_rdata = 32'hBADBAD00;
        step();
        mem_ready = 1'b0;
        chk("ready_in_idle_instr", instr, 32'hCAFEF00D);
        chk("ready_in_idle_valid", 32'(instr_valid), 32'd1);

        // Misaligned PC faults immediately and stays faulted until reset.
        curr_addr   = 32'h00000102;
        fetch_start = 1'b1;
        step();
        chk("misalign_fault", 32'(fault), 32'd1);
        chk("misalign_mem_req", 32'(mem_req), 32'd0);
        chk("misalign_busy", 32'(busy), 32'd0);
        curr_addr = 32'h00000200;
        reqs = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (mem_req || busy || !fault) reqs++;
        end
        fetch_start = 1'b0;
        chk("err_ignores_fetch", 32'(reqs), 32'd0);
        do_reset();
        chk("err_cleared_by_rst", 32'(fault), 32'd0);

        // Timeout: 16 REQ cycles without mem_ready, then fault.
        curr_addr   = 32'h00000200;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        reqs = 0;
        fault_cycle = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_req) reqs++;
            if (fault) begin
                fault_cycle = c;
                break;
            end
            step();
        end
        chk("timeout_req_cycles", 32'(reqs), 32'd16);
        chk("timeout_fault_cycle", 32'(fault_cycle), 32'd17);
        chk("timeout_busy", 32'(busy), 32'd0);
        do_reset();

        // Reset in the second REQ cycle aborts the fetch with no pc_update.
        do_fetch(vecs[0]);
        curr_addr   = 32'h00000300;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("abort_req1", 32'(mem_req), 32'd1);
        step();
        chk("abort_req2", 32'(mem_req), 32'd1);
        mem_ready = 1'b0;
        do_reset();
        check_reset_vals("abort");
        for (int c = 0; c < 4; c++) step();
        chk("abort_no_update_busy", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch sequencer that drives the program counter's update side. It reads the current PC, issues a read request to instruction memory, and waits on a ready handshake. It then latches the returned instruction word and pulses `pc_update` with `next_addr` = PC + 4 so the PC register advances. It sits between the multi-cycle control FSM (which requests fetches), the PC register, and the instruction memory port.

## Interface
Parameters:
- `BUS_WIDTH`, 32, width of address and instruction data.
- `TIMEOUT`, 16, cycles allowed in REQ without `mem_ready` before faulting (valid range 2..255).

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_start`  in  1  control FSM requests one fetch. Sampled only in IDLE.
- `curr_addr`  in  BUS_WIDTH  current PC value from the PC register.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  BUS_WIDTH  read address. Valid while `mem_req`=1.
- `mem_rdata`  in  BUS_WIDTH  instruction word. Valid when `mem_ready`=1.
- `mem_ready`  in  1  memory completes the read this cycle.
- `pc_update`  out  1  one-cycle strobe to the PC register.
- `next_addr`  out  BUS_WIDTH  address loaded into the PC when `pc_update`=1.
- `instr`  out  BUS_WIDTH  latched instruction word.
- `instr_valid`  out  1  `instr` holds the result of the last completed fetch.
- `busy`  out  1  a fetch is in progress (REQ or UPD).
- `fault`  out  1  sticky error: misaligned PC or memory timeout.

## Operation
- All outputs are registered.
- Reset values: `mem_req`=0, `mem_addr`=0, `pc_update`=0, `next_addr`=0, `instr`=32'h00000013 (NOP), `instr_valid`=0, `busy`=0, `fault`=0. State = IDLE, timeout counter = 0.
- States: IDLE, REQ, UPD, ERR.
- **IDLE**
  - `fetch_start`=1 and `curr_addr[1:0]`=0: latch `curr_addr` into `mem_addr`, clear `instr_valid`, clear the counter, go to REQ.
  - `fetch_start`=1 and `curr_addr[1:0]`≠0: set `fault`, go to ERR.
  - Otherwise remain in IDLE.
- **REQ**
  - `mem_req`=1 and `busy`=1 throughout; `mem_addr` is held constant.
  - `mem_ready`=1: capture `mem_rdata` into `instr`, set `next_addr` = `mem_addr` + 4 modulo 2^BUS_WIDTH (carry discarded, so 32'hFFFFFFFC wraps to 0), go to UPD.
  - `mem_ready`=0: increment the counter. If the counter reaches `TIMEOUT`-1 without `mem_ready`, set `fault` and go to ERR.
- **UPD**
  - `pc_update`=1, `instr_valid`=1, `mem_req`=0, `busy`=1.
  - Go to IDLE unconditionally.
- **ERR**
  - `fault`=1, `mem_req`=0, `pc_update`=0, `busy`=0.
  - `fetch_start` is ignored.
  - The only exit is `rst`.
- `instr_valid` stays 1 after UPD until the next accepted `fetch_start`.
- `next_addr` keeps its last value outside UPD.
- `fetch_start` while `busy`=1 is ignored; it is neither queued nor an error.
- `mem_ready` outside REQ is ignored. `instr` is not modified.
- `rst` in any state, including mid-REQ, forces reset values at that edge. No `pc_update` is issued for an aborted fetch.

## Timing
- Edge 0 samples `fetch_start`=1. In cycle 1 the block is in REQ with `mem_req`=1.
- Zero-wait memory (`mem_ready`=1 in cycle 1): cycle 2 has `pc_update`=1. The PC holds `next_addr` from edge 3, and the block is back in IDLE in cycle 3.
- Minimum of 3 cycles from `fetch_start` to the next acceptable `fetch_start`. Each memory wait cycle adds one.
- `pc_update` is never high for more than one consecutive cycle.
- `mem_req` deasserts in the cycle after `mem_ready`.
- Timeout: with `mem_ready` held low, ERR is entered after `TIMEOUT` cycles in REQ.

## Test plan
- Reset, then `curr_addr`=0x00000100 and `fetch_start` pulse, with `mem_ready`=1 and `mem_rdata`=0x00500093 in the first REQ cycle:
  - `mem_addr`=0x100.
  - `pc_update` high exactly in cycle 2 with `next_addr`=0x104.
  - `instr`=0x00500093, `instr_valid`=1.
- Same fetch with `mem_ready` delayed 3 cycles: `mem_req` high for 4 cycles, `pc_update` in cycle 5, `fetch_start` pulses during `busy` ignored.
- `curr_addr`=0xFFFFFFFC: `next_addr`=0x00000000 at `pc_update`.
- `curr_addr`=0x00000102 with `fetch_start`: `fault`=1 next cycle, `mem_req` never asserted, later `fetch_start` ignored until `rst`.
- `mem_ready` held 0 with `TIMEOUT`=16: `fault` rises after 16 REQ cycles and `pc_update` stays 0.
- Assert `rst` in the second REQ cycle: all outputs return to reset values after that edge, `instr`=0x00000013, no `pc_update`.
